// File: rtl/onewire_presence_responder.sv
// 1-wire responder: answers a master reset pulse with a presence pulse,
// receives one command byte over write slots, then returns one data byte
// over read slots.
// Signalling: O_PRESENCE_DONE and O_CMD_VALID are single-cycle pulses.
// O_CMD stays stable until the next O_CMD_VALID pulse.
// O_DBG_STATE exposes the FSM state for debug and checkers.
module onewire_presence_responder #(
  parameter int CLK_PER_US   = 12,
  parameter int RST_MIN_US   = 400,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_LEN_US  = 120,
  parameter int SAMPLE_US    = 30,
  parameter int TX_HOLD_US   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I_ONE_WIRE,
  output logic       O_ONE_WIRE,
  input  logic [7:0] I_TX_BYTE,
  output logic       O_PRESENCE_DONE,
  output logic [7:0] O_CMD,
  output logic       O_CMD_VALID,
  output logic       O_BUSY,
  output logic [2:0] O_DBG_STATE
);

  localparam int RST_CYC  = RST_MIN_US * CLK_PER_US;
  localparam int PW_CYC   = PRES_WAIT_US * CLK_PER_US;
  localparam int PL_CYC   = PRES_LEN_US * CLK_PER_US;
  localparam int SMP_CYC  = SAMPLE_US * CLK_PER_US;
  localparam int HOLD_CYC = TX_HOLD_US * CLK_PER_US;
  localparam int MAX_A    = (RST_CYC > PL_CYC) ? RST_CYC : PL_CYC;
  localparam int MAX_B    = (PW_CYC > SMP_CYC) ? PW_CYC : SMP_CYC;
  localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC  = (MAX_C > HOLD_CYC) ? MAX_C : HOLD_CYC;
  localparam int CW       = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] RST_SAT   = CW'(RST_CYC);
  localparam logic [CW-1:0] PW_LAST   = CW'(PW_CYC - 1);
  localparam logic [CW-1:0] PL_LAST   = CW'(PL_CYC - 1);
  localparam logic [CW-1:0] SMP_LAST  = CW'(SMP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PRES = 3'd1,
    PRESENCE  = 3'd2,
    RX_CMD    = 3'd3,
    TX_DATA   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          slot_q, slot_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    tx_q, tx_d;
  logic          drive_q, drive_d;
  logic          pres_done_q, pres_done_d;
  logic          cmd_valid_q, cmd_valid_d;

  logic line, fall, rise, rst_pulse;

  // Input synchroniser, edge detect and saturating low-time counter.
  always_comb begin
    sync1_d   = I_ONE_WIRE;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    line      = sync2_q;
    fall      = prev_q & ~line;
    rise      = ~prev_q & line;
    low_cnt_d = low_cnt_q;
    if (line) begin
      low_cnt_d = '0;
    end else if (!drive_q && (low_cnt_q != RST_SAT)) begin
      // Only the master's own low time counts toward a reset pulse.
      low_cnt_d = low_cnt_q + CW'(1);
    end
    rst_pulse = rise && (low_cnt_q == RST_SAT);
  end

  // Protocol FSM: next state, slot timing, shift register and pulses.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    slot_d      = slot_q;
    sr_d        = sr_q;
    cmd_d       = cmd_q;
    tx_d        = tx_q;
    drive_d     = drive_q;
    pres_done_d = 1'b0;
    cmd_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Short lows are ignored; only a reset pulse (below) leaves IDLE.
      end
      WAIT_PRES: begin
        if (timer_q == PW_LAST) begin
          state_d = PRESENCE;
          timer_d = '0;
          drive_d = 1'b1;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      PRESENCE: begin
        if (timer_q == PL_LAST) begin
          state_d     = RX_CMD;
          drive_d     = 1'b0;
          pres_done_d = 1'b1;
          bit_idx_d   = '0;
          slot_d      = 1'b0;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + CW'(1);
        end
      end
      RX_CMD: begin
        if (slot_q) begin
          if (timer_q == SMP_LAST) begin
            // LSB arrives first, so shift in from the top.
            sr_d   = {line, sr_q[7:1]};
            slot_d = 1'b0;
            if (bit_idx_q == 3'd7) begin
              cmd_d       = {line, sr_q[7:1]};
              cmd_valid_d = 1'b1;
              tx_d        = I_TX_BYTE;
              bit_idx_d   = '0;
              state_d     = TX_DATA;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            timer_d = timer_q + CW'(1);
          end
        end else if (fall) begin
          slot_d  = 1'b1;
          timer_d = '0;
        end
      end
      TX_DATA: begin
        if (slot_q) begin
          // Holding the line low for a 0 bit; falls are ignored meanwhile.
          if (timer_q == HOLD_LAST) begin
            drive_d = 1'b0;
            slot_d  = 1'b0;
            if (bit_idx_q == 3'd7) state_d = IDLE;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            timer_d = timer_q + CW'(1);
          end
        end else if (fall) begin
          if (!tx_q[bit_idx_q]) begin
            drive_d = 1'b1;
            slot_d  = 1'b1;
            timer_d = '0;
          end else if (bit_idx_q == 3'd7) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        drive_d = 1'b0;
      end
    endcase

    // A reset pulse wins over everything and discards any partial byte.
    if (rst_pulse) begin
      state_d     = WAIT_PRES;
      timer_d     = '0;
      bit_idx_d   = '0;
      slot_d      = 1'b0;
      drive_d     = 1'b0;
      cmd_d       = cmd_q;
      tx_d        = tx_q;
      cmd_valid_d = 1'b0;
      pres_done_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      low_cnt_q   <= '0;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      slot_q      <= 1'b0;
      sr_q        <= '0;
      cmd_q       <= '0;
      tx_q        <= '0;
      drive_q     <= 1'b0;
      pres_done_q <= 1'b0;
      cmd_valid_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      low_cnt_q   <= low_cnt_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      slot_q      <= slot_d;
      sr_q        <= sr_d;
      cmd_q       <= cmd_d;
      tx_q        <= tx_d;
      drive_q     <= drive_d;
      pres_done_q <= pres_done_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign O_ONE_WIRE      = ~drive_q;
  assign O_PRESENCE_DONE = pres_done_q;
  assign O_CMD           = cmd_q;
  assign O_CMD_VALID     = cmd_valid_q;
  assign O_BUSY          = (state_q != IDLE);
  assign O_DBG_STATE     = state_q;

endmodule
